// File: rtl/odo_round_key_sequencer_pkg.sv
// Shared Odo round-key definitions: table geometry, sequencer FSM encodings,
// capture-pipe entry type and a flat-key slice helper.
package odo_round_key_sequencer_pkg;

    localparam int unsigned NUM_ROUNDS  = 9;
    localparam int unsigned KEY_W       = 10;
    localparam int unsigned PERIOD_W    = 4;
    localparam int unsigned ROM_LAT_DEF = 1;
    localparam int unsigned FLAT_W      = NUM_ROUNDS * KEY_W;

    localparam logic [PERIOD_W-1:0] LAST_IDX = PERIOD_W'(NUM_ROUNDS - 1);

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FETCH  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // One in-flight ROM read: which table slot the returning key belongs to.
    typedef struct packed {
        logic                vld;
        logic [PERIOD_W-1:0] idx;
    } cap_t;

    function automatic logic [KEY_W-1:0] key_slice(input logic [FLAT_W-1:0]   flat,
                                                    input logic [PERIOD_W-1:0] idx);
        key_slice = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (idx == PERIOD_W'(i)) key_slice = flat[i*KEY_W +: KEY_W];
        end
    endfunction

endpackage

// File: rtl/odo_round_key_sequencer_if.sv
// Round controller / key ROM / hashing core side of the round-key sequencer.
interface odo_round_key_sequencer_if;
    import odo_round_key_sequencer_pkg::*;

    logic                start;
    logic                busy;
    logic [PERIOD_W-1:0] period;
    logic [KEY_W-1:0]    rom_key;
    logic                key_valid;
    logic                key_ready;
    logic [KEY_W-1:0]    key_data;
    logic [PERIOD_W-1:0] key_idx;
    logic                key_last;
    logic [FLAT_W-1:0]   keys_flat;
    logic                keys_valid;
    logic                done;

    modport master (
        input  start, rom_key, key_ready,
        output busy, period, key_valid, key_data, key_idx, key_last,
               keys_flat, keys_valid, done
    );

    modport slave (
        output start, rom_key, key_ready,
        input  busy, period, key_valid, key_data, key_idx, key_last,
               keys_flat, keys_valid, done
    );

endinterface

// File: rtl/odo_key_capture_pipe.sv
// Delays each issued table index by the ROM latency so it lines up with rom_key.
module odo_key_capture_pipe
    import odo_round_key_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = ROM_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  cap_t cap_in,
    output cap_t cap_out
);

    cap_t stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= cap_in;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign cap_out = stage_q[DEPTH-1];

endmodule

// File: rtl/odo_round_key_sequencer.sv
// Fetches all round keys from an external registered ROM into a buffer, then
// streams them out and exposes them as one flat word.
module odo_round_key_sequencer
    import odo_round_key_sequencer_pkg::*;
#(
    parameter int unsigned ROM_LAT = ROM_LAT_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    odo_round_key_sequencer_if.master  bus
);

    state_t              state_q,      state_d;
    logic [PERIOD_W-1:0] period_q,     period_d;
    logic                issuing_q,    issuing_d;
    logic                busy_q,       busy_d;
    logic                key_valid_q,  key_valid_d;
    logic [PERIOD_W-1:0] key_idx_q,    key_idx_d;
    logic [KEY_W-1:0]    key_data_q,   key_data_d;
    logic                key_last_q,   key_last_d;
    logic                keys_valid_q, keys_valid_d;
    logic                done_q,       done_d;
    logic [FLAT_W-1:0]   keys_q;

    cap_t                cap_in;
    cap_t                cap_out;
    logic                wr_en_c;
    logic                last_wr_c;
    logic [PERIOD_W-1:0] nxt_idx_c;
    logic [KEY_W-1:0]    first_key_c;

    assign cap_in.vld = issuing_q;
    assign cap_in.idx = period_q;

    odo_key_capture_pipe #(
        .DEPTH (ROM_LAT)
    ) u_capture_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .cap_in  (cap_in),
        .cap_out (cap_out)
    );

    assign wr_en_c     = cap_out.vld && (state_q == ST_FETCH);
    assign last_wr_c   = wr_en_c && (cap_out.idx == LAST_IDX);
    assign nxt_idx_c   = key_idx_q + PERIOD_W'(1);
    // Slot 0 may land on the same edge we enter STREAM (single-round tables).
    assign first_key_c = (wr_en_c && cap_out.idx == PERIOD_W'(0)) ? bus.rom_key
                                                                   : key_slice(keys_q, PERIOD_W'(0));

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        issuing_d    = issuing_q;
        busy_d       = busy_q;
        key_valid_d  = key_valid_q;
        key_idx_d    = key_idx_q;
        key_data_d   = key_data_q;
        key_last_d   = key_last_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d      = ST_FETCH;
                    busy_d       = 1'b1;
                    period_d     = '0;
                    issuing_d    = 1'b1;
                    keys_valid_d = 1'b0;
                    key_idx_d    = '0;
                end
            end
            ST_FETCH: begin
                if (issuing_q) begin
                    if (period_q == LAST_IDX) issuing_d = 1'b0;
                    else                      period_d  = period_q + PERIOD_W'(1);
                end
                if (last_wr_c) begin
                    state_d      = ST_STREAM;
                    keys_valid_d = 1'b1;
                    key_valid_d  = 1'b1;
                    key_idx_d    = '0;
                    key_data_d   = first_key_c;
                    key_last_d   = (LAST_IDX == PERIOD_W'(0));
                end
            end
            ST_STREAM: begin
                if (key_valid_q && bus.key_ready) begin
                    if (key_last_q) begin
                        state_d     = ST_DONE;
                        key_valid_d = 1'b0;
                        key_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        key_idx_d  = nxt_idx_c;
                        key_data_d = key_slice(keys_q, nxt_idx_c);
                        key_last_d = (nxt_idx_c == LAST_IDX);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            period_q     <= '0;
            issuing_q    <= 1'b0;
            busy_q       <= 1'b0;
            key_valid_q  <= 1'b0;
            key_idx_q    <= '0;
            key_data_q   <= '0;
            key_last_q   <= 1'b0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            issuing_q    <= issuing_d;
            busy_q       <= busy_d;
            key_valid_q  <= key_valid_d;
            key_idx_q    <= key_idx_d;
            key_data_q   <= key_data_d;
            key_last_q   <= key_last_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
        end
    end

    // Key buffer; doubles as the flat parallel view
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_q <= '0;
        end else if (wr_en_c) begin
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                if (cap_out.idx == PERIOD_W'(i)) keys_q[i*KEY_W +: KEY_W] <= bus.rom_key;
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.period     = period_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.key_data   = key_data_q;
    assign bus.key_idx    = key_idx_q;
    assign bus.key_last   = key_last_q;
    assign bus.keys_flat  = keys_q;
    assign bus.keys_valid = keys_valid_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Directed bench for odo_round_key_sequencer: ROM_LAT=1 main instance plus a
// ROM_LAT=2 instance sharing the same bench key table.
module tb_odo_round_key_sequencer;

    logic clk;
    logic rst_n;

    odo_round_key_sequencer_if bus ();
    odo_round_key_sequencer_if bus2 ();

    odo_round_key_sequencer #(.ROM_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    odo_round_key_sequencer #(.ROM_LAT(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] t0 [9] = '{10'h337, 10'h36e, 10'h2ab, 10'h312, 10'h312,
                           10'h010, 10'h150, 10'h0a7, 10'h0c0};
    logic [9:0] t1 [9] = '{10'h001, 10'h3ff, 10'h155, 10'h2aa, 10'h100,
                           10'h080, 10'h040, 10'h020, 10'h111};
    logic [9:0] tab [16];
    logic [9:0] r1;

    // Bench key ROMs: one register stage for dut, two for dut2
    always @(posedge clk) begin
        bus.rom_key  <= tab[bus.period];
        r1           <= tab[bus2.period];
        bus2.rom_key <= r1;
    end

    int vecs;
    int errs;

    logic [9:0] b_data [32];
    logic [3:0] b_idx  [32];
    logic       b_last [32];
    logic [3:0] per_log [16];
    int n_beats, done_cnt, stall_err, first_valid_c, done_c;
    bit timed_out;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic load_table(input int sel);
        for (int k = 0; k < 16; k++) tab[k] = 10'h3ff;
        for (int k = 0; k < 9; k++)  tab[k] = (sel == 1) ? t1[k] : t0[k];
    endtask

    function automatic logic [89:0] flat_of(input int sel);
        logic [89:0] f;
        f = '0;
        for (int k = 0; k < 9; k++) f[k*10 +: 10] = (sel == 1) ? t1[k] : t0[k];
        return f;
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Drives key_ready and logs beats / done / stalls until busy falls after done.
    task automatic collect(input bit rnd, input bit poke);
        logic [9:0] pd;
        logic [3:0] pi;
        bit pstall, poked, fin;
        n_beats = 0; done_cnt = 0; stall_err = 0; first_valid_c = -1; done_c = -1;
        pstall = 0; poked = 0; fin = 0; timed_out = 0; pd = '0; pi = '0;
        for (int k = 0; k < 32; k++) begin b_data[k] = '0; b_idx[k] = '0; b_last[k] = 0; end
        for (int c = 0; c < 200 && !fin; c++) begin
            if (c < 16) per_log[c] = bus.period;
            if (bus.key_valid && first_valid_c < 0) first_valid_c = c;
            if (bus.done) begin done_cnt++; if (done_c < 0) done_c = c; end
            if (pstall && (!bus.key_valid || bus.key_data !== pd || bus.key_idx !== pi)) stall_err++;
            if (done_c >= 0 && c > done_c && !bus.busy) begin
                fin = 1;
            end else begin
                bus.key_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke && !poked && n_beats == 2 && bus.key_valid) begin
                    bus.start = 1'b1;
                    poked = 1;
                end
                if (bus.key_valid && bus.key_ready && n_beats < 32) begin
                    b_data[n_beats] = bus.key_data;
                    b_idx[n_beats]  = bus.key_idx;
                    b_last[n_beats] = bus.key_last;
                    n_beats++;
                end
                pstall = bus.key_valid && !bus.key_ready;
                pd = bus.key_data;
                pi = bus.key_idx;
                step();
                bus.start = 1'b0;
            end
        end
        if (!fin) timed_out = 1;
        bus.key_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vecs++; if ({bus.busy, bus.key_valid, bus.key_last, bus.keys_valid, bus.done} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b expected 00000",
                             {bus.busy, bus.key_valid, bus.key_last, bus.keys_valid, bus.done}); end
        vecs++; if (bus.period !== 4'd0) begin errs++; $display("FAIL reset_period: got %h expected 0", bus.period); end
        vecs++; if (bus.key_idx !== 4'd0) begin errs++; $display("FAIL reset_key_idx: got %h expected 0", bus.key_idx); end
        vecs++; if (bus.key_data !== 10'd0) begin errs++; $display("FAIL reset_key_data: got %h expected 0", bus.key_data); end
        vecs++; if (bus.keys_flat !== 90'd0) begin errs++; $display("FAIL reset_keys_flat: got %h expected 0", bus.keys_flat); end
        rst_n = 1'b1;
        repeat (2) step();
        vecs++; if ({bus.busy, bus.keys_valid, bus.key_valid} !== 3'b0) begin
            errs++; $display("FAIL idle_after_reset: got %b expected 000", {bus.busy, bus.keys_valid, bus.key_valid}); end
    endtask

    task automatic test_basic();
        load_table(0);
        pulse_start();
        vecs++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL start_busy: got %b expected 1", bus.busy); end
        collect(0, 0);
        vecs++; if (timed_out) begin errs++; $display("FAIL basic_timeout: got timeout expected done"); end
        for (int c = 0; c < 10; c++) begin
            vecs++; if (per_log[c] !== 4'((c > 8) ? 8 : c)) begin
                errs++; $display("FAIL basic_period[%0d]: got %h expected %h", c, per_log[c], 4'((c > 8) ? 8 : c)); end
        end
        vecs++; if (first_valid_c !== 10) begin errs++; $display("FAIL basic_first_valid: got %0d expected 10", first_valid_c); end
        vecs++; if (done_c !== 19) begin errs++; $display("FAIL basic_done_cycle: got %0d expected 19", done_c); end
        vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        vecs++; if (n_beats !== 9) begin errs++; $display("FAIL basic_beats: got %0d expected 9", n_beats); end
        for (int k = 0; k < 9; k++) begin
            vecs++; if ({b_data[k], b_idx[k], b_last[k]} !== {t0[k], 4'(k), 1'(k == 8)}) begin
                errs++; $display("FAIL basic_beat[%0d]: got %h/%0d/%b expected %h/%0d/%b",
                                 k, b_data[k], b_idx[k], b_last[k], t0[k], k, k == 8); end
        end
        vecs++; if (bus.keys_valid !== 1'b1) begin errs++; $display("FAIL basic_keys_valid: got %b expected 1", bus.keys_valid); end
        vecs++; if (bus.keys_flat[9:0] !== 10'h337) begin errs++; $display("FAIL basic_flat_lo: got %h expected 337", bus.keys_flat[9:0]); end
        vecs++; if (bus.keys_flat[89:80] !== 10'h0c0) begin errs++; $display("FAIL basic_flat_hi: got %h expected 0c0", bus.keys_flat[89:80]); end
        vecs++; if (bus.keys_flat !== flat_of(0)) begin errs++; $display("FAIL basic_flat: got %h expected %h", bus.keys_flat, flat_of(0)); end
    endtask

    task automatic test_back_to_back();
        vecs++; if (bus.keys_valid !== 1'b1) begin errs++; $display("FAIL b2b_sticky: got %b expected 1", bus.keys_valid); end
        load_table(1);
        pulse_start();
        vecs++; if ({bus.keys_valid, bus.busy} !== 2'b01) begin
            errs++; $display("FAIL b2b_start_clears: got %b expected 01", {bus.keys_valid, bus.busy}); end
        collect(0, 0);
        vecs++; if (timed_out || n_beats !== 9) begin errs++; $display("FAIL b2b_beats: got %0d expected 9", n_beats); end
        for (int k = 0; k < 9; k++) begin
            vecs++; if ({b_data[k], b_idx[k]} !== {t1[k], 4'(k)}) begin
                errs++; $display("FAIL b2b_beat[%0d]: got %h/%0d expected %h/%0d", k, b_data[k], b_idx[k], t1[k], k); end
        end
        vecs++; if (bus.keys_flat !== flat_of(1)) begin errs++; $display("FAIL b2b_flat: got %h expected %h", bus.keys_flat, flat_of(1)); end
    endtask

    task automatic test_ready_random();
        load_table(0);
        pulse_start();
        collect(1, 0);
        vecs++; if (timed_out || n_beats !== 9) begin errs++; $display("FAIL rnd_beats: got %0d expected 9", n_beats); end
        for (int k = 0; k < 9; k++) begin
            vecs++; if ({b_data[k], b_idx[k], b_last[k]} !== {t0[k], 4'(k), 1'(k == 8)}) begin
                errs++; $display("FAIL rnd_beat[%0d]: got %h/%0d/%b expected %h/%0d", k, b_data[k], b_idx[k], b_last[k], t0[k], k); end
        end
        vecs++; if (stall_err !== 0) begin errs++; $display("FAIL rnd_stall_stable: got %0d expected 0", stall_err); end
        vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL rnd_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        int extra;
        load_table(1);
        pulse_start();
        repeat (3) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        collect(0, 1);
        vecs++; if (timed_out || n_beats !== 9) begin errs++; $display("FAIL ign_beats: got %0d expected 9", n_beats); end
        for (int k = 0; k < 9; k++) begin
            vecs++; if (b_data[k] !== t1[k]) begin errs++; $display("FAIL ign_beat[%0d]: got %h expected %h", k, b_data[k], t1[k]); end
        end
        vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL ign_done_count: got %0d expected 1", done_cnt); end
        extra = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.busy || bus.done) extra++;
            step();
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL ign_no_queued_run: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        load_table(0);
        pulse_start();
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (bus.key_valid && bus.key_idx == 4'd4) hit = 1;
            else step();
        end
        vecs++; if (!hit) begin errs++; $display("FAIL mid_reach_beat4: got timeout expected beat 4"); end
        rst_n = 1'b0;
        #2;
        vecs++; if ({bus.busy, bus.key_valid, bus.key_last, bus.keys_valid, bus.done} !== 5'b0) begin
            errs++; $display("FAIL mid_reset_ctrl: got %b expected 00000",
                             {bus.busy, bus.key_valid, bus.key_last, bus.keys_valid, bus.done}); end
        vecs++; if ({bus.period, bus.key_idx, bus.key_data} !== 18'd0) begin
            errs++; $display("FAIL mid_reset_data: got %h/%h/%h expected 0/0/0", bus.period, bus.key_idx, bus.key_data); end
        vecs++; if (bus.keys_flat !== 90'd0) begin errs++; $display("FAIL mid_reset_flat: got %h expected 0", bus.keys_flat); end
        step();
        rst_n = 1'b1;
        step();
        load_table(1);
        pulse_start();
        collect(0, 0);
        vecs++; if (timed_out || n_beats !== 9 || first_valid_c !== 10) begin
            errs++; $display("FAIL mid_rerun: got %0d beats first %0d expected 9 beats first 10", n_beats, first_valid_c); end
        for (int k = 0; k < 9; k++) begin
            vecs++; if ({b_data[k], b_idx[k]} !== {t1[k], 4'(k)}) begin
                errs++; $display("FAIL mid_beat[%0d]: got %h/%0d expected %h/%0d", k, b_data[k], b_idx[k], t1[k], k); end
        end
        vecs++; if (bus.keys_flat !== flat_of(1)) begin errs++; $display("FAIL mid_flat: got %h expected %h", bus.keys_flat, flat_of(1)); end
    endtask

    task automatic test_rom_lat2();
        int vc;
        bit idle;
        load_table(0);
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        vc = -1;
        for (int c = 0; c < 30 && vc < 0; c++) begin
            if (bus2.key_valid) vc = c;
            else step();
        end
        vecs++; if (vc !== 11) begin errs++; $display("FAIL lat2_first_valid: got %0d expected 11", vc); end
        vecs++; if (bus2.keys_valid !== 1'b1) begin errs++; $display("FAIL lat2_keys_valid: got %b expected 1", bus2.keys_valid); end
        vecs++; if (bus2.key_data !== 10'h337) begin errs++; $display("FAIL lat2_first_key: got %h expected 337", bus2.key_data); end
        vecs++; if ({bus2.keys_flat[29:20], bus2.keys_flat[39:30], bus2.keys_flat[49:40], bus2.keys_flat[59:50]}
                    !== {10'h2ab, 10'h312, 10'h312, 10'h010}) begin
            errs++; $display("FAIL lat2_slots2to5: got %h %h %h %h expected 2ab 312 312 010",
                             bus2.keys_flat[29:20], bus2.keys_flat[39:30], bus2.keys_flat[49:40], bus2.keys_flat[59:50]); end
        vecs++; if (bus2.keys_flat !== flat_of(0)) begin errs++; $display("FAIL lat2_flat: got %h expected %h", bus2.keys_flat, flat_of(0)); end
        idle = 0;
        for (int c = 0; c < 40 && !idle; c++) begin
            if (!bus2.busy) idle = 1;
            else step();
        end
        vecs++; if (!idle) begin errs++; $display("FAIL lat2_drain: got busy expected idle"); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.key_ready = 1'b1;
        bus2.start = 1'b0;
        bus2.key_ready = 1'b1;
        load_table(0);
        test_reset();
        test_basic();
        test_back_to_back();
        test_ready_random();
        test_start_ignored();
        test_reset_mid();
        test_rom_lat2();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
